// File: rtl/column_scan_loader.sv
// column_scan_loader
//   Streams configuration into a vertically tiled CLB column. Words arrive on a
//   valid/ready interface and are shifted out MSB-first, one bit per cycle:
//   first CLB_LEN bits into the clb chain, then CONN_LEN bits into the conn
//   chain. A trailing word carries a CRC-8 (poly 0x07, init 0x00) over all
//   shifted bits in shift order. scan_clk_en gates the external scan clock.
//
// Handshake: a word transfers on a rising clk edge where cfg_valid && cfg_ready.
//   cfg_ready depends only on registered state, never on cfg_valid. The
//   producer holds cfg_data stable while cfg_valid is high and not accepted.
//
// Ports
//   clk, rst_n            fabric clock, asynchronous active-low reset
//   start, abort          begin a load (IDLE only) / return to IDLE (any state)
//   cfg_valid/ready/data  configuration word stream
//   clb_scan_in/en        serial data and shift enable for the clb chain
//   conn_scan_in/en       serial data and shift enable for the conn chain
//   scan_clk_en           high exactly on shift cycles
//   busy, done, error     status: not idle / good-CRC pulse / sticky CRC error
//   state_dbg             current FSM state, for debug and checkers
module column_scan_loader #(
    parameter int NUM_TILES = 8,
    parameter int CLB_BITS  = 8,
    parameter int CONN_BITS = 8,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              clb_scan_in,
    output logic              clb_scan_en,
    output logic              conn_scan_in,
    output logic              conn_scan_en,
    output logic              scan_clk_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        state_dbg
);

    localparam int CLB_LEN  = NUM_TILES * CLB_BITS;
    localparam int CONN_LEN = NUM_TILES * CONN_BITS;
    localparam int MAX_LEN  = (CLB_LEN > CONN_LEN) ? CLB_LEN : CONN_LEN;
    localparam int CW       = $clog2(MAX_LEN + 1);
    localparam int SW       = $clog2(WORD_W + 1);

    localparam logic [CW-1:0] CLB_WORDS  = CW'(CLB_LEN / WORD_W);
    localparam logic [CW-1:0] CONN_WORDS = CW'(CONN_LEN / WORD_W);
    localparam logic [CW-1:0] CLB_LAST   = CW'(CLB_LEN - 1);
    localparam logic [CW-1:0] CONN_LAST  = CW'(CONN_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD_CLB  = 2'd1,
        S_LOAD_CONN = 2'd2,
        S_CHECK     = 2'd3
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] sh_reg;    // bit WORD_W-1 is the bit on scan_in
    logic [SW-1:0]     sh_cnt;    // bits still to shift from sh_reg
    logic [CW-1:0]     bit_cnt;   // bits shifted into the current chain
    logic [CW-1:0]     word_cnt;  // words accepted for the current chain
    logic [7:0]        crc;

    logic          loading;
    logic          shifting;
    logic          accept;
    logic          scan_bit;
    logic          crc_fb;
    logic [7:0]    crc_next;
    logic [CW-1:0] chain_words;
    logic [CW-1:0] chain_last;

    always_comb begin
        loading     = (state == S_LOAD_CLB) || (state == S_LOAD_CONN);
        shifting    = loading && (sh_cnt != '0);
        chain_words = (state == S_LOAD_CLB) ? CLB_WORDS : CONN_WORDS;
        chain_last  = (state == S_LOAD_CLB) ? CLB_LAST : CONN_LAST;
        // A new word may land while the last bit of the previous one shifts,
        // but never once the current chain has all its words: a word must
        // not straddle the clb/conn boundary.
        cfg_ready   = (loading && (sh_cnt <= SW'(1)) && (word_cnt < chain_words))
                    || (state == S_CHECK);
        accept      = cfg_valid && cfg_ready;
        scan_bit    = sh_reg[WORD_W-1];
        crc_fb      = crc[7] ^ scan_bit;
        crc_next    = {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
    end

    // The shifter zero-fills, so scan_in is 0 whenever its chain is not shifting.
    assign clb_scan_en  = shifting && (state == S_LOAD_CLB);
    assign conn_scan_en = shifting && (state == S_LOAD_CONN);
    assign clb_scan_in  = (state == S_LOAD_CLB) && scan_bit;
    assign conn_scan_in = (state == S_LOAD_CONN) && scan_bit;
    assign scan_clk_en  = clb_scan_en | conn_scan_en;
    assign busy         = (state != S_IDLE);
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sh_reg   <= '0;
            sh_cnt   <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            crc      <= 8'h00;
            done     <= 1'b0;
            error    <= 1'b0;
        end else if (abort) begin
            // Discard everything in flight; error keeps its value.
            state    <= S_IDLE;
            sh_reg   <= '0;
            sh_cnt   <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD_CLB;
                        error    <= 1'b0;
                        crc      <= 8'h00;
                        sh_reg   <= '0;
                        sh_cnt   <= '0;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end
                S_LOAD_CLB, S_LOAD_CONN: begin
                    if (shifting) begin
                        crc     <= crc_next;
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                    if (accept) begin
                        sh_reg   <= cfg_data;
                        sh_cnt   <= SW'(WORD_W);
                        word_cnt <= word_cnt + CW'(1);
                    end else if (shifting) begin
                        sh_reg <= sh_reg << 1;
                        sh_cnt <= sh_cnt - SW'(1);
                    end
                    // No word can be accepted on the chain's last bit, so the
                    // counter reset here never races an accept.
                    if (shifting && (bit_cnt == chain_last)) begin
                        state    <= (state == S_LOAD_CLB) ? S_LOAD_CONN : S_CHECK;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        state <= S_IDLE;
                        if (cfg_data[7:0] == crc) done  <= 1'b1;
                        else                      error <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_column_scan_loader.sv
module tb_column_scan_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic       clb_scan_in;
    logic       clb_scan_en;
    logic       conn_scan_in;
    logic       conn_scan_en;
    logic       scan_clk_en;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] state_dbg;

    column_scan_loader #(
        .NUM_TILES(2), .CLB_BITS(8), .CONN_BITS(8), .WORD_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .clb_scan_in(clb_scan_in), .clb_scan_en(clb_scan_en),
        .conn_scan_in(conn_scan_in), .conn_scan_en(conn_scan_en),
        .scan_clk_en(scan_clk_en), .busy(busy), .done(done), .error(error),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Monitor: collects shifted bits and protocol violations at negedge.
    logic [63:0] clb_seq  = '0;
    logic [63:0] conn_seq = '0;
    int clb_n = 0, conn_n = 0, sclk_n = 0, done_n = 0, clb_idle_n = 0, viol = 0;

    always @(negedge clk) begin
        if (clb_scan_en) begin
            clb_seq = {clb_seq[62:0], clb_scan_in};
            clb_n++;
        end
        if (conn_scan_en) begin
            conn_seq = {conn_seq[62:0], conn_scan_in};
            conn_n++;
        end
        if (scan_clk_en) sclk_n++;
        if (done) done_n++;
        if (state_dbg == 2'd1 && !scan_clk_en) clb_idle_n++;
        if ((scan_clk_en !== (clb_scan_en | conn_scan_en)) ||
            (clb_scan_en && conn_scan_en) ||
            (!clb_scan_en && clb_scan_in) ||
            (!conn_scan_en && conn_scan_in))
            viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // CRC-8 poly 0x07, init 0, MSB-first over a 32-bit stream.
    function automatic logic [7:0] crc8_stream(input logic [31:0] s);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ s[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // driver: present one word and hold it until accepted (bounded wait)
    task automatic send_word(input logic [7:0] w, output bit ok);
        ok        = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = w;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [7:0] crc_word, input int stall,
                            input bit poke, input bit exp_done, input bit exp_err,
                            input int exp_idle);
        int c0, n0, s0, d0, i0;
        bit ok;
        c0 = clb_n; n0 = conn_n; s0 = sclk_n; d0 = done_n; i0 = clb_idle_n;
        pulse_start();
        check({tag, ".start_clears_error"}, error, 0);
        check({tag, ".busy_after_start"}, busy, 1);
        send_word(8'hA5, ok);
        if (stall > 0) begin
            repeat (stall + 7) @(posedge clk);
            #1;
        end
        send_word(8'h3C, ok);
        if (poke) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        send_word(8'hF0, ok);
        send_word(8'h0F, ok);
        send_word(crc_word, ok);
        check({tag, ".handshake"}, ok, 1);
        repeat (2) @(posedge clk);
        #1;
        check({tag, ".clb_bits"}, clb_n - c0, 16);
        check({tag, ".clb_seq"}, clb_seq[15:0], 16'hA53C);
        check({tag, ".conn_bits"}, conn_n - n0, 16);
        check({tag, ".conn_seq"}, conn_seq[15:0], 16'hF00F);
        check({tag, ".scan_clk_cycles"}, sclk_n - s0, 32);
        check({tag, ".done_pulses"}, done_n - d0, exp_done);
        check({tag, ".error"}, error, exp_err);
        check({tag, ".idle_after"}, busy, 0);
        check({tag, ".clb_stall_cycles"}, clb_idle_n - i0, exp_idle);
    endtask

    logic [7:0] good_crc;

    initial begin
        bit ok;
        int c0, d0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
        good_crc = crc8_stream(32'hA53CF00F);

        // reset state
        #12;
        check("reset.outputs",
              {cfg_ready, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en,
               scan_clk_en, busy, done, error}, 0);
        check("reset.state", state_dbg, 0);
        rst_n = 1'b1;

        // normal load, held-valid back-to-back words
        run_load("normal", good_crc, 0, 1'b0, 1'b1, 1'b0, 1);

        // bad CRC: sticky error, no done
        run_load("badcrc", good_crc ^ 8'h01, 0, 1'b0, 1'b0, 1'b1, 1);
        repeat (3) @(posedge clk);
        #1;
        check("badcrc.sticky", error, 1);

        // valid gap of 5 cycles after word 1 (start also clears error)
        run_load("stall", good_crc, 5, 1'b0, 1'b1, 1'b0, 6);

        // abort during the 10th clb shift
        c0 = clb_n; d0 = done_n;
        pulse_start();
        send_word(8'hA5, ok);
        send_word(8'h3C, ok);
        @(posedge clk); #1;
        check("abort.shifting", clb_scan_en, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort.enables", {clb_scan_en, conn_scan_en, scan_clk_en}, 0);
        check("abort.busy", busy, 0);
        check("abort.ready", cfg_ready, 0);
        check("abort.clb_bits", clb_n - c0, 10);
        repeat (3) @(posedge clk); #1;
        check("abort.no_done", done_n - d0, 0);
        check("abort.error_kept", error, 0);

        // cfg_valid in IDLE consumes nothing
        cfg_valid = 1'b1; cfg_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_valid.ready", cfg_ready, 0);
            check("idle_valid.state", state_dbg, 0);
        end
        @(posedge clk); #1 cfg_valid = 1'b0;

        // start pulsed while busy must be ignored
        run_load("start_busy", good_crc, 0, 1'b1, 1'b1, 1'b0, 1);

        // async reset mid LOAD_CONN, then a fresh full load
        pulse_start();
        send_word(8'hA5, ok);
        send_word(8'h3C, ok);
        send_word(8'hF0, ok);
        #3;
        check("rst.conn_shifting", conn_scan_en, 1);
        rst_n = 1'b0;
        #1;
        check("rst.outputs",
              {cfg_ready, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en,
               scan_clk_en, busy, done, error}, 0);
        check("rst.state", state_dbg, 0);
        #10 rst_n = 1'b1;
        run_load("after_rst", good_crc, 0, 1'b0, 1'b1, 1'b0, 1);

        check("protocol_violations", viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
